buf_ram_1p_msk: RTL

- Parametrised single-port pixel buffer RAM that succeeds the fixed 128x64 buffer wrapper.
- Generalised depth, pixel width and pixels per word, with a per-pixel write mask and an optional output register stage.
- Built-in clear sequencer fills the whole array with a constant, for example when a new CTU starts.
- Used as on-chip line/CTU buffer storage in the encoder datapath (prediction, reconstruction, deblocking buffers).

---
 rtl/buf_ram_1p_msk.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/buf_ram_1p_msk.sv
// buf_ram_1p_msk
// Parametrised single-port pixel buffer RAM with a per-pixel write mask, an
// optional output register stage and a built-in clear sequencer that fills
// the whole array with CLR_VAL (for example at the start of a new CTU).
// While the clear sequencer runs, it owns the array and external accesses are
// dropped. Callers poll clr_busy_o.
module buf_ram_1p_msk #(
    parameter int                   ADDR_WIDTH = 7,
    parameter int                   PIX_NUM    = 8,
    parameter int                   PIX_WIDTH  = 8,
    parameter int                   OUT_REG    = 0,
    parameter logic [PIX_WIDTH-1:0] CLR_VAL    = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ce,
    input  logic                           we,
    input  logic [PIX_NUM-1:0]             msk,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [PIX_NUM*PIX_WIDTH-1:0]   data_i,
    output logic [PIX_NUM*PIX_WIDTH-1:0]   data_o,
    output logic                           rd_vld_o,
    input  logic                           clr_i,
    output logic                           clr_busy_o,
    output logic                           clr_done_o
);

    localparam int W     = PIX_NUM * PIX_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    // The counter is one bit wider than the address so that the terminal
    // compare never aliases with a wrapped value.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CLR  = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic [W-1:0]          r_mem [DEPTH];
    logic [W-1:0]          r_rd_data;
    logic                  r_rd_vld;

    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [W-1:0]          w_mem_din;
    logic [PIX_NUM-1:0]    w_pix_we;
    logic [PIX_NUM-1:0]    w_bwe_n;

    // External access is only honoured while the clear sequencer is idle.
    assign w_acc = ce & ~r_busy;
    assign w_wr  = w_acc & we;
    assign w_rd  = w_acc & ~we;

    // The sequencer takes over the address and data path while busy.
    assign w_mem_addr = r_busy ? r_cnt[ADDR_WIDTH-1:0] : addr;
    assign w_mem_din  = r_busy ? {PIX_NUM{CLR_VAL}} : data_i;

    // Per-pixel write enables. The storage is driven through an active-low
    // bit-write-enable, matching the polarity at the hard-macro boundary.
    generate
        for (genvar gi = 0; gi < PIX_NUM; gi++) begin : g_pix_we
            assign w_pix_we[gi] = r_busy | (w_wr & msk[gi]);
            assign w_bwe_n[gi]  = ~w_pix_we[gi];
        end
    endgenerate

    // Clear sequencer: IDLE -> CLR on a request, one word per cycle, done pulse after the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_i) begin
                        r_state <= S_CLR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: lane-masked writes from either the sequencer or the external port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PIX_NUM; i++) begin
            if (!w_bwe_n[i]) begin
                r_mem[w_mem_addr][i*PIX_WIDTH +: PIX_WIDTH] <= w_mem_din[i*PIX_WIDTH +: PIX_WIDTH];
            end
        end
    end

    // Registered read: data holds its last value when no read occurs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd;
            if (w_rd) begin
                r_rd_data <= r_mem[addr];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [W-1:0] r_out_data;
            logic         r_out_vld;

            // Optional second stage: captures only valid read results.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_data <= '0;
                    r_out_vld  <= 1'b0;
                end else begin
                    r_out_vld <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_out_data <= r_rd_data;
                    end
                end
            end

            assign data_o   = r_out_data;
            assign rd_vld_o = r_out_vld;
        end else begin : g_no_out_reg
            assign data_o   = r_rd_data;
            assign rd_vld_o = r_rd_vld;
        end
    endgenerate

    assign clr_busy_o = r_busy;
    assign clr_done_o = r_done;

endmodule
